// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle core state sequencer with FPU latency waits, memory handshake and perf counters
module exec_sequencer #(
  parameter int unsigned FADD_LAT  = 4,
  parameter int unsigned FMUL_LAT  = 3,
  parameter int unsigned FDIV_LAT  = 12,
  parameter int unsigned FSQRT_LAT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        fetch_done,
  input  logic        mem_done,
  input  logic        is_fadd,
  input  logic        is_fmul,
  input  logic        is_fdiv,
  input  logic        is_fsqrt,
  input  logic        is_load,
  input  logic        is_store,
  output logic [2:0]  state,
  output logic        fpu_busy,
  output logic        retire,
  output logic [31:0] instr_count,
  output logic [31:0] stall_cycles,
  output logic        halted
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WAIT   = 3'd4,
    MEM    = 3'd5,
    WRITE  = 3'd6,
    HALT   = 3'd7
  } state_t;
  state_t     cur, nxt;
  logic [7:0] wait_cnt, wait_nxt, lat;
  logic       fpu_sel, stall_inc;
  assign fpu_sel = is_fdiv | is_fsqrt | is_fmul | is_fadd;
  assign lat = is_fdiv  ? 8'(FDIV_LAT)  :
               is_fsqrt ? 8'(FSQRT_LAT) :
               is_fmul  ? 8'(FMUL_LAT)  : 8'(FADD_LAT);
  assign stall_inc = (cur == WAIT) | (cur == FETCH & ~fetch_done) | (cur == MEM & ~mem_done);
  assign state = cur;
  always_comb begin
    nxt      = cur;
    wait_nxt = wait_cnt;
    case (cur)
      IDLE:   nxt = start ? FETCH : IDLE;
      FETCH:  nxt = fetch_done ? DECODE : FETCH;
      DECODE: nxt = EXEC;
      EXEC: begin
        // FPU classes win over load/store; a single-cycle FPU op retires straight away
        if (fpu_sel && lat > 8'd1) begin
          nxt      = WAIT;
          wait_nxt = lat - 8'd1;
        end else begin
          nxt = (!fpu_sel && (is_load || is_store)) ? MEM : WRITE;
        end
      end
      WAIT: begin
        wait_nxt = wait_cnt - 8'd1;
        nxt      = (wait_cnt <= 8'd1) ? WRITE : WAIT;
      end
      MEM:    nxt = mem_done ? WRITE : MEM;
      WRITE:  nxt = halt_req ? HALT : FETCH;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
  // status flags are registered from the next state so they never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= IDLE;
      wait_cnt     <= 8'd0;
      fpu_busy     <= 1'b0;
      retire       <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      cur          <= nxt;
      wait_cnt     <= wait_nxt;
      fpu_busy     <= nxt == WAIT;
      retire       <= nxt == WRITE;
      halted       <= nxt == HALT;
      instr_count  <= instr_count + 32'(cur == WRITE);
      stall_cycles <= stall_cycles + 32'(stall_inc);
    end
  end
endmodule
